// File: rtl/nmea_pkg.sv
// Shared encodings for the two-receiver NMEA source arbiter: FSM states,
// framing characters and the counter width helper.
package nmea_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_REL  = 2'd2
    } arb_state_e;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/nmea_src_watchdog.sv
// Per-source idle counter: clears on every valid strobe, saturates at
// STALE_CYC and flags the source stale while saturated.
module nmea_src_watchdog
    import nmea_pkg::*;
#(
    parameter int STALE_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    output logic stale_o
);

    localparam int             W   = cnt_w(STALE_CYC);
    localparam logic [W-1:0]   SAT = W'(STALE_CYC);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (valid_i)
            cnt_d = '0;
        else if (cnt_q != SAT)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign stale_o = (cnt_q == SAT);

endmodule

// File: rtl/nmea_src_arb.sv
// Two-receiver NMEA byte-stream arbiter: locks onto one source per sentence
// ('$' .. LF) with timeout release. Optional counters under NMEA_ARB_STATS_EN.
module nmea_src_arb
    import nmea_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int STALE_CYC   = 50_000_000,
    parameter int PREF_SRC    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  char0,
    input  logic        valid0,
    input  logic [7:0]  char1,
    input  logic        valid1,
    output logic [7:0]  char_out,
    output logic        valid_out,
    output logic        owner,
    output logic        locked,
    output logic        abort,
`ifdef NMEA_ARB_STATS_EN
    output logic [15:0] good_cnt0,
    output logic [15:0] good_cnt1,
    output logic [15:0] to_cnt,
`endif
    output logic [1:0]  stale
);

    localparam int           TW   = cnt_w(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
    localparam logic         PREF0 = 1'(PREF_SRC);

    arb_state_e    state_q;
    logic [7:0]    char_q;
    logic          valid_q, owner_q, pref_q, locked_q, abort_q;
    logic [TW-1:0] cnt_q;
    logic [1:0]    stale_w;

    nmea_src_watchdog #(.STALE_CYC(STALE_CYC)) u_wd0 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid0), .stale_o(stale_w[0])
    );
    nmea_src_watchdog #(.STALE_CYC(STALE_CYC)) u_wd1 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid1), .stale_o(stale_w[1])
    );

    // A stale source only loses eligibility when the other one is still alive.
    logic cand0, cand1, grant, win;
    assign cand0 = valid0 && (char0 == ASCII_DOLLAR) && !(stale_w[0] && !stale_w[1]);
    assign cand1 = valid1 && (char1 == ASCII_DOLLAR) && !(stale_w[1] && !stale_w[0]);
    assign grant = cand0 | cand1;
    assign win   = (cand0 && cand1) ? pref_q : cand1;

    logic       own_v, own_lf, own_dlr, to_hit;
    logic [7:0] own_c;
    assign own_v   = owner_q ? valid1 : valid0;
    assign own_c   = owner_q ? char1  : char0;
    assign own_lf  = own_v && (own_c == ASCII_LF);
    assign own_dlr = own_v && (own_c == ASCII_DOLLAR);
    assign to_hit  = (cnt_q == TMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            char_q   <= '0;
            valid_q  <= 1'b0;
            owner_q  <= PREF0;
            pref_q   <= PREF0;
            locked_q <= 1'b0;
            abort_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        state_q  <= ST_LOCK;
                        owner_q  <= win;
                        char_q   <= ASCII_DOLLAR;
                        valid_q  <= 1'b1;
                        locked_q <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                ST_LOCK: begin
                    if (own_v) begin
                        char_q  <= own_c;
                        valid_q <= 1'b1;
                    end
                    // LF beats timeout in the same cycle; the owner's '$' restarts the window.
                    if (own_lf) begin
                        state_q  <= ST_REL;
                        locked_q <= 1'b0;
                        pref_q   <= owner_q;
                    end else if (own_dlr) begin
                        cnt_q <= '0;
                    end else if (to_hit) begin
                        state_q  <= ST_REL;
                        locked_q <= 1'b0;
                        abort_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign char_out  = char_q;
    assign valid_out = valid_q;
    assign owner     = owner_q;
    assign locked    = locked_q;
    assign abort     = abort_q;
    assign stale     = stale_w;

`ifdef NMEA_ARB_STATS_EN
    logic        lf_end, to_end;
    logic [15:0] good0_q, good1_q, to_q;
    assign lf_end = (state_q == ST_LOCK) && own_lf;
    assign to_end = (state_q == ST_LOCK) && !own_lf && !own_dlr && to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good0_q <= '0;
            good1_q <= '0;
            to_q    <= '0;
        end else begin
            if (lf_end && !owner_q && good0_q != 16'hFFFF) good0_q <= good0_q + 1'b1;
            if (lf_end &&  owner_q && good1_q != 16'hFFFF) good1_q <= good1_q + 1'b1;
            if (to_end && to_q != 16'hFFFF)                to_q    <= to_q + 1'b1;
        end
    end

    assign good_cnt0 = good0_q;
    assign good_cnt1 = good1_q;
    assign to_cnt    = to_q;
`endif

endmodule
